// File: rtl/sparc_ram_responder.sv
// sparc_ram_responder
// Memory-side responder for the SPARC MPU memory handshake. A request is
// captured when MOV is seen in IDLE. The FSM then waits LATENCY edges and
// commits the transfer against a big-endian byte RAM. After that it holds
// MOC high until the initiator drops MOV.
//
// Ports
//   Clk        system clock, rising edge
//   Clr        asynchronous active-low reset (does not clear Mem)
//   MOV        memory operation valid, held by initiator until MOC
//   ReadWrite  1 = read, 0 = write
//   Type       00 byte, 01 halfword, 10 word, 11 illegal
//   Address    byte address
//   DataIn     write data, right-justified
//   DataOut    read data, zero-extended, right-justified; holds last read
//   MOC        memory operation complete
//   AlignErr   transfer rejected (valid while MOC=1)
module sparc_ram_responder #(
   parameter int DEPTH   = 512,
   parameter int ADDR_W  = 9,
   parameter int LATENCY = 2
) (
   input  logic              Clk,
   input  logic              Clr,
   input  logic              MOV,
   input  logic              ReadWrite,
   input  logic [1:0]        Type,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       DataIn,
   output logic [31:0]       DataOut,
   output logic              MOC,
   output logic              AlignErr
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [3:0]          cnt_r;
   logic [3:0]          cnt_nxt_s;
   logic                capture_s;
   logic                commit_s;

   logic [ADDR_W-1:0]   addr_r;
   logic                rw_r;
   logic [1:0]          type_r;
   logic [31:0]         data_r;

   logic                align_err_s;
   logic [ADDR_W-1:0]   a1_s;
   logic [ADDR_W-1:0]   a2_s;
   logic [ADDR_W-1:0]   a3_s;
   logic [31:0]         rd_data_s;

   logic [7:0]          Mem [0:DEPTH-1];

   // Misalignment / illegal size check on the captured request
   function automatic logic align_err_f(input logic [1:0] ty, input logic [ADDR_W-1:0] a);
      logic err;
      case (ty)
         2'b00:   err = 1'b0;
         2'b01:   err = a[0];
         2'b10:   err = (a[1:0] != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

   // Byte lane addresses; aligned accesses never carry out of their unit
   always_comb begin
      a1_s        = addr_r + ADDR_W'(2'd1);
      a2_s        = addr_r + ADDR_W'(2'd2);
      a3_s        = addr_r + ADDR_W'(2'd3);
      align_err_s = align_err_f(type_r, addr_r);
   end

   // Big-endian read assembly, zero-extended
   always_comb begin
      rd_data_s = DataOut;
      case (type_r)
         2'b00:   rd_data_s = {24'h000000, Mem[addr_r]};
         2'b01:   rd_data_s = {16'h0000, Mem[addr_r], Mem[a1_s]};
         2'b10:   rd_data_s = {Mem[addr_r], Mem[a1_s], Mem[a2_s], Mem[a3_s]};
         default: rd_data_s = DataOut;
      endcase
   end

   // Next-state logic for the handshake FSM and latency counter
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      capture_s   = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (MOV) begin
               capture_s   = 1'b1;
               cnt_nxt_s   = LAT_M1;
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            // MOV is deliberately ignored here: a started transfer always commits
            if (cnt_r == 4'd0) begin
               commit_s    = 1'b1;
               state_nxt_s = S_RESP;
            end else begin
               cnt_nxt_s   = cnt_r - 4'd1;
            end
         end
         S_RESP: begin
            if (!MOV) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_RESP;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // FSM state, request capture and registered outputs
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_r  <= S_IDLE;
         cnt_r    <= 4'd0;
         addr_r   <= '0;
         rw_r     <= 1'b0;
         type_r   <= 2'b00;
         data_r   <= 32'h0000_0000;
         DataOut  <= 32'h0000_0000;
         MOC      <= 1'b0;
         AlignErr <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (capture_s) begin
            addr_r <= Address;
            rw_r   <= ReadWrite;
            type_r <= Type;
            data_r <= DataIn;
         end
         if (commit_s) begin
            MOC      <= 1'b1;
            AlignErr <= align_err_s;
            if (rw_r && !align_err_s) begin
               DataOut <= rd_data_s;
            end
         end else if ((state_r == S_RESP) && !MOV) begin
            MOC      <= 1'b0;
            AlignErr <= 1'b0;
         end
      end
   end

   // Storage write port; not reset so contents survive Clr
   always_ff @(posedge Clk) begin
      if (commit_s && !rw_r && !align_err_s) begin
         case (type_r)
            2'b00: begin
               Mem[addr_r] <= data_r[7:0];
            end
            2'b01: begin
               Mem[addr_r] <= data_r[15:8];
               Mem[a1_s]   <= data_r[7:0];
            end
            2'b10: begin
               Mem[addr_r] <= data_r[31:24];
               Mem[a1_s]   <= data_r[23:16];
               Mem[a2_s]   <= data_r[15:8];
               Mem[a3_s]   <= data_r[7:0];
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sparc_ram_responder.sv
// Self-checking bench for sparc_ram_responder. A reference byte array models
// the RAM; every request pushes its expected {AlignErr, DataOut} onto a
// scoreboard queue which is popped when MOC is observed.
module tb_sparc_ram_responder;

   localparam int LAT = 2;

   logic        Clk = 1'b0;
   logic        Clr;
   logic        MOV;
   logic        ReadWrite;
   logic [1:0]  Type;
   logic [8:0]  Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MOC;
   logic        AlignErr;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [7:0]  mm [512];
   logic [31:0] last_rd;
   logic [32:0] sb_q [$];

   sparc_ram_responder #(.DEPTH(512), .ADDR_W(9), .LATENCY(LAT)) dut (
      .Clk(Clk), .Clr(Clr), .MOV(MOV), .ReadWrite(ReadWrite), .Type(Type),
      .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC),
      .AlignErr(AlignErr)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: compute expectation and update model memory
   task automatic model(input logic rw, input logic [1:0] ty, input logic [8:0] a,
                        input logic [31:0] d);
      logic        err;
      logic [31:0] e;
      logic [8:0]  a1, a2, a3;
      a1  = a + 9'd1;
      a2  = a + 9'd2;
      a3  = a + 9'd3;
      err = (ty == 2'b11) || (ty == 2'b01 && a[0]) || (ty == 2'b10 && a[1:0] != 2'b00);
      e   = last_rd;
      if (!err) begin
         if (rw) begin
            if (ty == 2'b00)      e = {24'h0, mm[a]};
            else if (ty == 2'b01) e = {16'h0, mm[a], mm[a1]};
            else                  e = {mm[a], mm[a1], mm[a2], mm[a3]};
            last_rd = e;
         end else begin
            if (ty == 2'b00) mm[a] = d[7:0];
            else if (ty == 2'b01) begin mm[a] = d[15:8]; mm[a1] = d[7:0]; end
            else begin
               mm[a] = d[31:24]; mm[a1] = d[23:16]; mm[a2] = d[15:8]; mm[a3] = d[7:0];
            end
         end
      end
      sb_q.push_back({err, e});
   endtask

   // One full handshake; hold = extra cycles MOV stays high after MOC
   task automatic xfer(input string tag, input logic rw, input logic [1:0] ty,
                       input logic [8:0] a, input logic [31:0] d, input int hold);
      int          cyc;
      logic [32:0] exp;
      model(rw, ty, a, d);
      MOV = 1'b1; ReadWrite = rw; Type = ty; Address = a; DataIn = d;
      cyc = 0;
      while (cyc < 20) begin
         @(negedge Clk);
         cyc++;
         if (MOC) break;
      end
      exp = sb_q.pop_front();
      if (!MOC) begin
         chk({tag, "_timeout"}, 32'(MOC), 32'd1);
      end else begin
         chk({tag, "_lat"}, 32'(cyc), 32'(LAT + 1));
         chk({tag, "_data"}, DataOut, exp[31:0]);
         chk({tag, "_aerr"}, 32'(AlignErr), 32'(exp[32]));
      end
      for (int i = 0; i < hold; i++) begin
         DataIn  = ~d;
         Address = a + 9'd4;
         @(negedge Clk);
         chk({tag, "_hold_moc"}, 32'(MOC), 32'd1);
      end
      if (hold > 0) chk({tag, "_hold_data"}, DataOut, exp[31:0]);
      MOV = 1'b0;
      @(negedge Clk);
      chk({tag, "_moc_fall"}, 32'(MOC), 32'd0);
      chk({tag, "_aerr_fall"}, 32'(AlignErr), 32'd0);
   endtask

   initial begin
      int cyc;
      Clr = 1'b0; MOV = 1'b0; ReadWrite = 1'b0; Type = 2'b00;
      Address = 9'h000; DataIn = 32'h0; last_rd = 32'h0;
      repeat (3) @(negedge Clk);
      chk("rst_dout", DataOut, 32'h0);
      chk("rst_moc", 32'(MOC), 32'd0);
      chk("rst_aerr", 32'(AlignErr), 32'd0);
      Clr = 1'b1;
      @(negedge Clk);

      // Known contents, then a read so DataOut is non-zero before abort
      xfer("w010", 1'b0, 2'b10, 9'h010, 32'h11223344, 0);
      xfer("w000", 1'b0, 2'b10, 9'h000, 32'hCAFEF00D, 0);
      xfer("r010", 1'b1, 2'b10, 9'h010, 32'h0, 0);

      // Reset during WAIT of a word write: must never reach Mem
      MOV = 1'b1; ReadWrite = 1'b0; Type = 2'b10; Address = 9'h010; DataIn = 32'hDEADBEEF;
      @(negedge Clk);
      Clr = 1'b0;
      #1;
      chk("abort_moc", 32'(MOC), 32'd0);
      chk("abort_dout", DataOut, 32'h0);
      @(negedge Clk);
      @(negedge Clk);
      MOV = 1'b0; Clr = 1'b1; last_rd = 32'h0;
      @(negedge Clk);
      chk("abort_moc2", 32'(MOC), 32'd0);
      xfer("abort_rd", 1'b1, 2'b10, 9'h010, 32'h0, 0);

      // Word write/read and sub-word big-endian reads
      xfer("w020", 1'b0, 2'b10, 9'h020, 32'h12345678, 0);
      xfer("r020", 1'b1, 2'b10, 9'h020, 32'h0, 0);
      xfer("rb020", 1'b1, 2'b00, 9'h020, 32'h0, 0);
      xfer("rb023", 1'b1, 2'b00, 9'h023, 32'h0, 0);
      xfer("rb021", 1'b1, 2'b00, 9'h021, 32'h0, 0);
      xfer("rh022", 1'b1, 2'b01, 9'h022, 32'h0, 0);

      // Alignment errors: DataOut and Mem unchanged
      xfer("err_w1fd", 1'b1, 2'b10, 9'h1FD, 32'h0, 0);
      xfer("err_t11", 1'b0, 2'b11, 9'h000, 32'hFFFFFFFF, 0);
      xfer("err_h023", 1'b0, 2'b01, 9'h023, 32'h0000AAAA, 0);
      xfer("r000", 1'b1, 2'b10, 9'h000, 32'h0, 0);
      xfer("r020b", 1'b1, 2'b10, 9'h020, 32'h0, 0);

      // MOV held after MOC with changing inputs: no second transfer
      xfer("hold", 1'b0, 2'b00, 9'h030, 32'h000000AA, 5);
      xfer("hold_rd", 1'b1, 2'b00, 9'h030, 32'h0, 0);
      xfer("hold_rd4", 1'b1, 2'b00, 9'h034, 32'h0, 0);

      // MOV dropped during WAIT: commit still happens, 1-cycle MOC
      model(1'b0, 2'b00, 9'h031, 32'h0000005C);
      void'(sb_q.pop_front());
      MOV = 1'b1; ReadWrite = 1'b0; Type = 2'b00; Address = 9'h031; DataIn = 32'h5C;
      @(negedge Clk);
      MOV = 1'b0;
      cyc = 1;
      while (cyc < 20 && !MOC) begin
         @(negedge Clk);
         cyc++;
      end
      chk("drop_lat", 32'(cyc), 32'(LAT + 1));
      @(negedge Clk);
      chk("drop_pulse", 32'(MOC), 32'd0);
      xfer("drop_rd", 1'b1, 2'b00, 9'h031, 32'h0, 0);

      // Top-of-memory word: no wrap into address 0
      xfer("w1fc", 1'b0, 2'b10, 9'h1FC, 32'hA1B2C3D4, 0);
      xfer("rb1fc", 1'b1, 2'b00, 9'h1FC, 32'h0, 0);
      xfer("rb1fd", 1'b1, 2'b00, 9'h1FD, 32'h0, 0);
      xfer("rb1fe", 1'b1, 2'b00, 9'h1FE, 32'h0, 0);
      xfer("rb1ff", 1'b1, 2'b00, 9'h1FF, 32'h0, 0);
      xfer("rb000", 1'b1, 2'b00, 9'h000, 32'h0, 0);
      xfer("r000b", 1'b1, 2'b10, 9'h000, 32'h0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
